burst_sequencer: RTL and testbench
==================================

BURST_SEQUENCER -- requirements
Module: burst_sequencer

Interface
REQ-001 Parameters SHALL be:
- TW, 64, system-time width
- IW, 32, interval-counter width
- FW, 48, DDS frequency/step width
- RW, 32, DDS rate width
- NW, 16, pulse-count width
- DEPTH, 4, command-queue depth (power of 2, >=2)
REQ-002 Ports SHALL be (clock and reset first):
- CLK in 1 48 MHz clock
- RESET in 1 synchronous, active-high reset
- SYS_TIME in TW time loaded at next second mark
- SYS_TIME_UPDATE in 1 arm time load
- T1HZ in 1 asynchronous second mark
- CMD_VALID in 1 command offered
- CMD_READY out 1 queue not full
- CMD_FREQ in FW start frequency
- CMD_DFREQ in FW frequency step
- CMD_RATE in RW step rate
- CMD_TSTART in TW start time
- CMD_N in NW pulse count
- CMD_COH in 1 1 = coherent burst
- CMD_TB1, CMD_TI, CMD_TB2, CMD_TP in IW each blank1 / transmit / blank2 / receive intervals
- ABORT in 1 flush queue, stop burst
- DDS_FREQ, DDS_DFREQ out FW parameters to DDS
- DDS_RATE out RW parameter to DDS
- DDS_REQ out 1 four-phase request
- DDS_ACK in 1 four-phase acknowledge (already synchronised)
- DDS_START out 1 DDS run
- EN_IZ out 1 transmit enable
- EN_PR out 1 receive enable
- TIME out TW system time
- TIME_SYNCED out 1 time loaded since last arm
- CMD_DONE out 1 one-cycle pulse, burst finished
- CMD_LATE out 1 one-cycle pulse, start time already passed
- CMD_ERR out 1 one-cycle pulse, N=0 command discarded
- Q_LEVEL out $clog2(DEPTH)+1 queue occupancy

Function
REQ-003 T1HZ SHALL pass a 3-flop synchroniser; its rising edge is detected on flops 2/3.
REQ-004 TIME SHALL increment by 1 per cycle, wrapping modulo 2^TW.
REQ-005 On a T1HZ edge while SYS_TIME_UPDATE=1, TIME SHALL load SYS_TIME in place of incrementing, and TIME_SYNCED SHALL set.
REQ-006 A rising edge of SYS_TIME_UPDATE SHALL clear TIME_SYNCED.
REQ-007 The queue SHALL be a FIFO. A command is written when CMD_VALID and CMD_READY are both 1. CMD_READY = (Q_LEVEL<DEPTH). Simultaneous push and pop SHALL be permitted when the queue is full.
REQ-008 The FSM SHALL have states IDLE, WAIT_T, LOAD, BLANK1, TX, BLANK2, RX, END.
REQ-009 IDLE transitions:
- queue non-empty, head N=0 -> pop, pulse CMD_ERR, stay IDLE
- queue non-empty, head N>0 -> WAIT_T
REQ-010 WAIT_T SHALL pop the head and go to LOAD when TIME==TSTART.
REQ-011 If TIME>TSTART on the first WAIT_T cycle, WAIT_T SHALL pop, go to LOAD, and pulse CMD_LATE (unsigned compare, no wrap handling).
REQ-012 LOAD SHALL drive DDS_* from the popped command and raise DDS_REQ. It waits for DDS_ACK=1, drops DDS_REQ, waits for DDS_ACK=0, then goes to BLANK1.
REQ-013 LOAD SHALL be entered before every pulse when COH=0, and before the first pulse only when COH=1.
REQ-014 BLANK1, TX, BLANK2 and RX SHALL each last exactly interval+1 cycles (interval 0 -> 1 cycle).
REQ-015 EN_IZ SHALL be 1 exactly during TX, and EN_PR exactly during RX.
REQ-016 DDS_START SHALL go to 1 on the first TX cycle.
- COH=0: returns to 0 on the first BLANK2 cycle.
- COH=1: held through the burst, cleared on the final pulse's BLANK2.
REQ-017 END SHALL decrement the remaining-pulse counter.
- Count non-zero -> LOAD (COH=0) or BLANK1 (COH=1).
- Count zero -> pulse CMD_DONE, go to IDLE.
REQ-018 Back-to-back commands SHALL need no dead cycles beyond IDLE->WAIT_T.
REQ-019 ABORT SHALL, on the next edge:
- empty the queue
- go to IDLE
- force EN_IZ, EN_PR, DDS_START and DDS_REQ to 0
- not pulse CMD_DONE
TIME SHALL be unaffected.
REQ-020 ABORT during LOAD SHALL leave DDS_ACK ignored until the next LOAD.

Reset
REQ-021 RESET SHALL set:
- FSM = IDLE, queue empty, Q_LEVEL = 0, CMD_READY = 1
- TIME = 0, TIME_SYNCED = 0
- all enables, strobes and DDS_REQ = 0
- DDS_* data = all ones
REQ-022 RESET asserted mid-burst SHALL take effect on the next edge with no partial pulse.

Structure
REQ-023 Package burst_pkg SHALL hold the FSM state enum and the command struct type (fields per the CMD_* ports).
REQ-024 The queue SHALL be sub-module cmd_fifo, parametrised by DEPTH and payload width, with registered outputs (show-ahead head).

Verification
REQ-025 Sync: SYS_TIME=1000, arm, T1HZ edge -> TIME=1000 on the cycle after synchronised edge detect, TIME_SYNCED=1.
REQ-026 Incoherent burst: N=2, TB1=3, TI=5, TB2=2, TP=4, COH=0 ->
- two LOAD handshakes
- EN_IZ 6 cycles twice, EN_PR 5 cycles twice
- DDS_START low between pulses
- one CMD_DONE
REQ-027 Coherent burst: same intervals, COH=1, N=3 ->
- one handshake
- DDS_START continuous from first TX to final BLANK2
REQ-028 Queue: push 4 commands (DEPTH=4) -> CMD_READY=0, Q_LEVEL=4; 5th push stalls; commands execute in order.
REQ-029 Late/error: TSTART=TIME-10 -> CMD_LATE pulse and immediate LOAD; N=0 command -> CMD_ERR, no outputs toggled.
REQ-030 ABORT during TX of pulse 1 of 3 -> EN_IZ=0 next cycle, Q_LEVEL=0, no CMD_DONE; RESET mid-RX -> all outputs reset next cycle.

Source files
------------

// File: rtl/burst_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : burst_pkg
//  Purpose  : Shared types for the burst sequencer: FSM states and command.
//  Revision : 1.0 - initial release
// ============================================================================
package burst_pkg;

    localparam int c_tw = 64;
    localparam int c_iw = 32;
    localparam int c_fw = 48;
    localparam int c_rw = 32;
    localparam int c_nw = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT_T = 3'd1,
        LOAD   = 3'd2,
        BLANK1 = 3'd3,
        TX     = 3'd4,
        BLANK2 = 3'd5,
        RX     = 3'd6,
        END    = 3'd7
    } state_t;

    typedef struct packed {
        logic [c_fw-1:0] freq;
        logic [c_fw-1:0] dfreq;
        logic [c_rw-1:0] rate;
        logic [c_tw-1:0] tstart;
        logic [c_nw-1:0] n;
        logic            coh;
        logic [c_iw-1:0] tb1;
        logic [c_iw-1:0] ti;
        logic [c_iw-1:0] tb2;
        logic [c_iw-1:0] tp;
    } cmd_t;

    localparam int c_cmd_w = $bits(cmd_t);

endpackage
`default_nettype wire

// File: rtl/cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : cmd_fifo
//  Purpose  : Show-ahead command FIFO with registered head and level.
//  Revision : 1.0 - initial release
// ============================================================================
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     i_clr,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_din,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_lw = c_aw + 1;
    localparam logic [c_lw-1:0] c_full = c_lw'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_rd;
    logic [c_aw-1:0]  r_wr;
    logic [c_lw-1:0]  r_level;
    logic [WIDTH-1:0] r_head;
    logic [c_aw-1:0]  w_rd_inc;
    logic             w_pop;
    logic             w_push;

    assign w_rd_inc = r_rd + c_aw'(1);
    assign w_pop    = i_pop & (r_level != '0);
    // A pop frees a slot in the same cycle, so a full queue can still accept.
    assign w_push   = i_push & ((r_level != c_full) | w_pop);

    always_ff @(posedge CLK) begin
        if (w_push && !i_clr) begin
            r_mem[r_wr] <= i_din;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET || i_clr) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_level <= '0;
            r_head  <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + c_aw'(1);
            end
            if (w_pop) begin
                r_rd <= w_rd_inc;
            end
            r_level <= r_level + c_lw'(w_push) - c_lw'(w_pop);
            // The head tracks whatever entry becomes oldest after this edge.
            if (w_push && (r_level == '0 || (w_pop && r_level == c_lw'(1)))) begin
                r_head <= i_din;
            end else if (w_pop && r_level != c_lw'(1)) begin
                r_head <= r_mem[w_rd_inc];
            end
        end
    end

    assign o_head  = r_head;
    assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/burst_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : burst_sequencer
//  Purpose  : Time-triggered radar burst sequencer with DDS handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module burst_sequencer
    import burst_pkg::*;
#(
    parameter int TW    = c_tw,
    parameter int IW    = c_iw,
    parameter int FW    = c_fw,
    parameter int RW    = c_rw,
    parameter int NW    = c_nw,
    parameter int DEPTH = 4
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [TW-1:0]          SYS_TIME,
    input  logic                   SYS_TIME_UPDATE,
    input  logic                   T1HZ,
    input  logic                   CMD_VALID,
    output logic                   CMD_READY,
    input  logic [FW-1:0]          CMD_FREQ,
    input  logic [FW-1:0]          CMD_DFREQ,
    input  logic [RW-1:0]          CMD_RATE,
    input  logic [TW-1:0]          CMD_TSTART,
    input  logic [NW-1:0]          CMD_N,
    input  logic                   CMD_COH,
    input  logic [IW-1:0]          CMD_TB1,
    input  logic [IW-1:0]          CMD_TI,
    input  logic [IW-1:0]          CMD_TB2,
    input  logic [IW-1:0]          CMD_TP,
    input  logic                   ABORT,
    output logic [FW-1:0]          DDS_FREQ,
    output logic [FW-1:0]          DDS_DFREQ,
    output logic [RW-1:0]          DDS_RATE,
    output logic                   DDS_REQ,
    input  logic                   DDS_ACK,
    output logic                   DDS_START,
    output logic                   EN_IZ,
    output logic                   EN_PR,
    output logic [TW-1:0]          TIME,
    output logic                   TIME_SYNCED,
    output logic                   CMD_DONE,
    output logic                   CMD_LATE,
    output logic                   CMD_ERR,
    output logic [$clog2(DEPTH):0] Q_LEVEL
);

    localparam int c_lw = $clog2(DEPTH) + 1;
    localparam logic [c_lw-1:0] c_depth = c_lw'(DEPTH);

    state_t          r_state, w_next;
    cmd_t            w_cmd_in, w_head;
    logic [c_lw-1:0] w_level;
    logic            w_empty, w_pop, w_start, w_late_cmp, w_first;
    logic            w_err, w_late, w_done;
    logic [2:0]      r_t1hz_sync;
    logic            r_upd_d, w_t1hz_edge;
    logic [TW-1:0]   r_time;
    logic            r_synced;
    logic            r_wait_prev, r_ack_seen;
    logic [IW-1:0]   r_cnt, w_next_ival;
    logic [NW-1:0]   r_remain;
    logic            r_coh;
    logic [IW-1:0]   r_tb1, r_ti, r_tb2, r_tp;
    logic [FW-1:0]   r_freq, r_dfreq, r_dds_freq, r_dds_dfreq;
    logic [RW-1:0]   r_rate, r_dds_rate;
    logic            r_dds_req, r_dds_start, r_en_iz, r_en_pr;

    always_comb begin
        w_cmd_in = '{freq: CMD_FREQ, dfreq: CMD_DFREQ, rate: CMD_RATE,
                     tstart: CMD_TSTART, n: CMD_N, coh: CMD_COH,
                     tb1: CMD_TB1, ti: CMD_TI, tb2: CMD_TB2, tp: CMD_TP};
    end

    cmd_fifo #(.DEPTH(DEPTH), .WIDTH(c_cmd_w)) u_cmd_fifo (
        .CLK     (CLK),
        .RESET   (RESET),
        .i_clr   (ABORT),
        .i_push  (CMD_VALID & CMD_READY),
        .i_pop   (w_pop),
        .i_din   (w_cmd_in),
        .o_head  (w_head),
        .o_level (w_level)
    );

    assign w_empty     = (w_level == '0);
    assign w_t1hz_edge = r_t1hz_sync[1] & ~r_t1hz_sync[2];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_t1hz_sync <= '0;
            r_upd_d     <= 1'b0;
            r_time      <= '0;
            r_synced    <= 1'b0;
        end else begin
            r_t1hz_sync <= {r_t1hz_sync[1:0], T1HZ};
            r_upd_d     <= SYS_TIME_UPDATE;
            if (w_t1hz_edge && SYS_TIME_UPDATE) begin
                r_time   <= SYS_TIME;
                r_synced <= 1'b1;
            end else begin
                r_time <= r_time + TW'(1);
                if (SYS_TIME_UPDATE && !r_upd_d) begin
                    r_synced <= 1'b0;
                end
            end
        end
    end

    // Lateness is judged only on the first WAIT_T cycle; afterwards wait for equality.
    assign w_first    = (r_state == WAIT_T) && !r_wait_prev;
    assign w_late_cmp = w_first && (r_time > w_head.tstart);
    assign w_start    = (r_time == w_head.tstart) || w_late_cmp;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (!w_empty && w_head.n != '0) w_next = WAIT_T;
            WAIT_T:  if (w_start) w_next = LOAD;
            LOAD:    if (r_ack_seen && !DDS_ACK) w_next = BLANK1;
            BLANK1:  if (r_cnt == '0) w_next = TX;
            TX:      if (r_cnt == '0) w_next = BLANK2;
            BLANK2:  if (r_cnt == '0) w_next = RX;
            RX:      if (r_cnt == '0) w_next = END;
            END:     w_next = (r_remain == NW'(1)) ? IDLE : (r_coh ? BLANK1 : LOAD);
            default: w_next = IDLE;
        endcase
        if (ABORT) begin
            w_next = IDLE;
        end
    end

    always_comb begin
        w_pop  = 1'b0;
        w_err  = 1'b0;
        w_late = 1'b0;
        w_done = 1'b0;
        if (!ABORT) begin
            w_err  = (r_state == IDLE) && !w_empty && (w_head.n == '0);
            w_late = w_late_cmp;
            w_pop  = w_err || ((r_state == WAIT_T) && w_start);
            w_done = (r_state == END) && (r_remain == NW'(1));
        end
    end

    always_comb begin
        case (w_next)
            BLANK1:  w_next_ival = r_tb1;
            TX:      w_next_ival = r_ti;
            BLANK2:  w_next_ival = r_tb2;
            RX:      w_next_ival = r_tp;
            default: w_next_ival = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wait_prev <= 1'b0;
            r_ack_seen  <= 1'b0;
            r_cnt       <= '0;
            r_remain    <= '0;
            r_coh       <= 1'b0;
            r_tb1       <= '0;
            r_ti        <= '0;
            r_tb2       <= '0;
            r_tp        <= '0;
            r_freq      <= '0;
            r_dfreq     <= '0;
            r_rate      <= '0;
            r_dds_freq  <= '1;
            r_dds_dfreq <= '1;
            r_dds_rate  <= '1;
            r_dds_req   <= 1'b0;
            r_dds_start <= 1'b0;
            r_en_iz     <= 1'b0;
            r_en_pr     <= 1'b0;
        end else begin
            r_wait_prev <= (r_state == WAIT_T);
            r_en_iz     <= (w_next == TX);
            r_en_pr     <= (w_next == RX);

            if (r_state == WAIT_T && w_next == LOAD) begin
                r_remain <= w_head.n;
                r_coh    <= w_head.coh;
                r_tb1    <= w_head.tb1;
                r_ti     <= w_head.ti;
                r_tb2    <= w_head.tb2;
                r_tp     <= w_head.tp;
                r_freq   <= w_head.freq;
                r_dfreq  <= w_head.dfreq;
                r_rate   <= w_head.rate;
            end else if (r_state == END) begin
                r_remain <= r_remain - NW'(1);
            end

            if (w_next != r_state) begin
                r_cnt <= w_next_ival;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - IW'(1);
            end

            // Four-phase request: raise on LOAD entry, drop on ACK, leave once ACK falls.
            if (w_next != LOAD) begin
                r_dds_req <= 1'b0;
            end else if (r_state != LOAD) begin
                r_dds_req   <= 1'b1;
                r_ack_seen  <= 1'b0;
                r_dds_freq  <= (r_state == WAIT_T) ? w_head.freq  : r_freq;
                r_dds_dfreq <= (r_state == WAIT_T) ? w_head.dfreq : r_dfreq;
                r_dds_rate  <= (r_state == WAIT_T) ? w_head.rate  : r_rate;
            end else if (!r_ack_seen && DDS_ACK) begin
                r_dds_req  <= 1'b0;
                r_ack_seen <= 1'b1;
            end

            if (w_next == TX && r_state != TX) begin
                r_dds_start <= 1'b1;
            end else if (w_next == IDLE) begin
                r_dds_start <= 1'b0;
            end else if (w_next == BLANK2 && r_state != BLANK2 &&
                         (!r_coh || r_remain == NW'(1))) begin
                r_dds_start <= 1'b0;
            end
        end
    end

    assign CMD_READY   = (w_level < c_depth);
    assign Q_LEVEL     = w_level;
    assign TIME        = r_time;
    assign TIME_SYNCED = r_synced;
    assign DDS_FREQ    = r_dds_freq;
    assign DDS_DFREQ   = r_dds_dfreq;
    assign DDS_RATE    = r_dds_rate;
    assign DDS_REQ     = r_dds_req;
    assign DDS_START   = r_dds_start;
    assign EN_IZ       = r_en_iz;
    assign EN_PR       = r_en_pr;
    assign CMD_DONE    = w_done;
    assign CMD_LATE    = w_late;
    assign CMD_ERR     = w_err;

endmodule
`default_nettype wire

// File: tb/tb_burst_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_burst_sequencer
//  Purpose  : Directed self-checking bench for burst_sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_burst_sequencer;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [63:0] SYS_TIME = '0;
    logic        SYS_TIME_UPDATE = 1'b0;
    logic        T1HZ = 1'b0;
    logic        CMD_VALID = 1'b0;
    logic        CMD_READY;
    logic [47:0] CMD_FREQ = '0, CMD_DFREQ = '0;
    logic [31:0] CMD_RATE = '0;
    logic [63:0] CMD_TSTART = '0;
    logic [15:0] CMD_N = '0;
    logic        CMD_COH = 1'b0;
    logic [31:0] CMD_TB1 = 32'd3, CMD_TI = 32'd5, CMD_TB2 = 32'd2, CMD_TP = 32'd4;
    logic        ABORT = 1'b0;
    logic [47:0] DDS_FREQ, DDS_DFREQ;
    logic [31:0] DDS_RATE;
    logic        DDS_REQ, DDS_ACK, DDS_START, EN_IZ, EN_PR;
    logic [63:0] TIME;
    logic        TIME_SYNCED, CMD_DONE, CMD_LATE, CMD_ERR;
    logic [2:0]  Q_LEVEL;

    burst_sequencer dut (
        .CLK(CLK), .RESET(RESET), .SYS_TIME(SYS_TIME), .SYS_TIME_UPDATE(SYS_TIME_UPDATE),
        .T1HZ(T1HZ), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_FREQ(CMD_FREQ),
        .CMD_DFREQ(CMD_DFREQ), .CMD_RATE(CMD_RATE), .CMD_TSTART(CMD_TSTART), .CMD_N(CMD_N),
        .CMD_COH(CMD_COH), .CMD_TB1(CMD_TB1), .CMD_TI(CMD_TI), .CMD_TB2(CMD_TB2),
        .CMD_TP(CMD_TP), .ABORT(ABORT), .DDS_FREQ(DDS_FREQ), .DDS_DFREQ(DDS_DFREQ),
        .DDS_RATE(DDS_RATE), .DDS_REQ(DDS_REQ), .DDS_ACK(DDS_ACK), .DDS_START(DDS_START),
        .EN_IZ(EN_IZ), .EN_PR(EN_PR), .TIME(TIME), .TIME_SYNCED(TIME_SYNCED),
        .CMD_DONE(CMD_DONE), .CMD_LATE(CMD_LATE), .CMD_ERR(CMD_ERR), .Q_LEVEL(Q_LEVEL)
    );

    always #5 CLK = ~CLK;

    // DDS model: acknowledge follows request through a two-flop delay.
    logic [1:0] ack_pipe = 2'b00;
    always @(posedge CLK) ack_pipe <= {ack_pipe[0], DDS_REQ};
    assign DDS_ACK = ack_pipe[1];

    int m_iz_hi = 0, m_iz_rise = 0, m_pr_hi = 0, m_st_hi = 0, m_st_rise = 0;
    int m_req_rise = 0, m_done = 0, m_late = 0, m_err = 0;
    logic [63:0] m_iz_time = '0, m_req_time = '0;
    logic p_iz = 1'b0, p_st = 1'b0, p_req = 1'b0;
    logic [47:0] freq_log[$];

    always @(posedge CLK) begin
        #2;
        if (EN_IZ) m_iz_hi++;
        if (EN_IZ && !p_iz) begin m_iz_rise++; m_iz_time = TIME; end
        if (EN_PR) m_pr_hi++;
        if (DDS_START) m_st_hi++;
        if (DDS_START && !p_st) m_st_rise++;
        if (DDS_REQ && !p_req) begin m_req_rise++; m_req_time = TIME; freq_log.push_back(DDS_FREQ); end
        if (CMD_DONE) m_done++;
        if (CMD_LATE) m_late++;
        if (CMD_ERR) m_err++;
        p_iz = EN_IZ; p_st = DDS_START; p_req = DDS_REQ;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [47:0] f, input logic [63:0] ts, input logic [15:0] n, input logic coh);
        CMD_FREQ = f; CMD_DFREQ = f + 48'd1; CMD_RATE = 32'h55;
        CMD_TSTART = ts; CMD_N = n; CMD_COH = coh; CMD_VALID = 1'b1;
        @(posedge CLK); #1 CMD_VALID = 1'b0;
        @(negedge CLK);
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        for (int i = 0; i < budget && m_done < target; i++) @(negedge CLK);
        check(tag, 64'(m_done >= target), 64'd1);
    endtask

    int s_req, s_iz_hi, s_iz_rise, s_pr_hi, s_st_hi, s_st_rise, s_done, s_late, s_err, s_log;
    logic [63:0] t0;
    logic accepted;

    task automatic snap();
        s_req = m_req_rise; s_iz_hi = m_iz_hi; s_iz_rise = m_iz_rise; s_pr_hi = m_pr_hi;
        s_st_hi = m_st_hi; s_st_rise = m_st_rise; s_done = m_done; s_late = m_late;
        s_err = m_err; s_log = freq_log.size();
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        check("rst_time", TIME, 64'd0);
        check("rst_synced", 64'(TIME_SYNCED), 64'd0);
        check("rst_qlevel", 64'(Q_LEVEL), 64'd0);
        check("rst_ready", 64'(CMD_READY), 64'd1);
        check("rst_dds_freq", 64'(DDS_FREQ), 64'hFFFF_FFFF_FFFF);
        check("rst_dds_rate", 64'(DDS_RATE), 64'hFFFF_FFFF);
        check("rst_dds_req", 64'(DDS_REQ), 64'd0);
        check("rst_en_iz", 64'(EN_IZ), 64'd0);
        check("rst_dds_start", 64'(DDS_START), 64'd0);
        RESET = 1'b0;
        repeat (7) @(posedge CLK);
        #1 check("time_count", TIME, 64'd7);

        // Time load on a synchronised second mark
        @(negedge CLK);
        SYS_TIME = 64'd1000; SYS_TIME_UPDATE = 1'b1; T1HZ = 1'b1;
        repeat (2) @(posedge CLK);
        #1 check("sync_not_yet", 64'(TIME == 64'd1000), 64'd0);
        @(posedge CLK);
        #1 check("sync_time", TIME, 64'd1000);
        check("sync_flag", 64'(TIME_SYNCED), 64'd1);
        @(posedge CLK);
        #1 check("sync_incr", TIME, 64'd1001);
        @(negedge CLK);
        SYS_TIME_UPDATE = 1'b0; T1HZ = 1'b0;
        repeat (5) @(negedge CLK);
        SYS_TIME_UPDATE = 1'b1;
        @(posedge CLK);
        #1 check("arm_clears_sync", 64'(TIME_SYNCED), 64'd0);
        @(negedge CLK);
        SYS_TIME_UPDATE = 1'b0;

        // Incoherent burst, N=2
        snap(); t0 = TIME + 64'd20;
        push(48'h111, t0, 16'd2, 1'b0);
        wait_done(s_done + 1, 500, "inc_done_seen");
        repeat (3) @(negedge CLK);
        check("inc_handshakes", 64'(m_req_rise - s_req), 64'd2);
        check("inc_iz_cycles", 64'(m_iz_hi - s_iz_hi), 64'd12);
        check("inc_iz_pulses", 64'(m_iz_rise - s_iz_rise), 64'd2);
        check("inc_pr_cycles", 64'(m_pr_hi - s_pr_hi), 64'd10);
        check("inc_start_runs", 64'(m_st_rise - s_st_rise), 64'd2);
        check("inc_start_cycles", 64'(m_st_hi - s_st_hi), 64'd12);
        check("inc_done_count", 64'(m_done - s_done), 64'd1);
        check("inc_tx2_time", m_iz_time, t0 + 64'd36);
        check("inc_late_none", 64'(m_late - s_late), 64'd0);

        // Coherent burst, N=3
        snap(); t0 = TIME + 64'd20;
        push(48'h222, t0, 16'd3, 1'b1);
        wait_done(s_done + 1, 500, "coh_done_seen");
        repeat (3) @(negedge CLK);
        check("coh_handshakes", 64'(m_req_rise - s_req), 64'd1);
        check("coh_start_runs", 64'(m_st_rise - s_st_rise), 64'd1);
        check("coh_start_cycles", 64'(m_st_hi - s_st_hi), 64'd44);
        check("coh_iz_cycles", 64'(m_iz_hi - s_iz_hi), 64'd18);
        check("coh_pr_cycles", 64'(m_pr_hi - s_pr_hi), 64'd15);
        check("coh_tx3_time", m_iz_time, t0 + 64'd49);
        check("coh_dds_freq", 64'(DDS_FREQ), 64'h222);
        check("coh_dds_dfreq", 64'(DDS_DFREQ), 64'h223);

        // Queue fill, stall and in-order execution
        snap(); t0 = TIME + 64'd100;
        push(48'hA01, t0, 16'd1, 1'b0);
        push(48'hA02, 64'd0, 16'd1, 1'b0);
        push(48'hA03, 64'd0, 16'd1, 1'b0);
        push(48'hA04, 64'd0, 16'd1, 1'b0);
        check("q_full_level", 64'(Q_LEVEL), 64'd4);
        check("q_full_ready", 64'(CMD_READY), 64'd0);
        CMD_FREQ = 48'hA05; CMD_DFREQ = 48'hA06; CMD_TSTART = 64'd0; CMD_N = 16'd1; CMD_VALID = 1'b1;
        repeat (3) @(negedge CLK);
        check("q_stall_level", 64'(Q_LEVEL), 64'd4);
        accepted = 1'b0;
        for (int i = 0; i < 300 && !accepted; i++) begin
            if (CMD_READY) begin
                @(posedge CLK); #1 CMD_VALID = 1'b0; accepted = 1'b1;
            end
            @(negedge CLK);
        end
        CMD_VALID = 1'b0;
        check("q_fifth_accepted", 64'(accepted), 64'd1);
        wait_done(s_done + 5, 1500, "q_done_seen");
        repeat (3) @(negedge CLK);
        check("q_done_count", 64'(m_done - s_done), 64'd5);
        check("q_late_count", 64'(m_late - s_late), 64'd4);
        for (int k = 0; k < 5; k++)
            check($sformatf("q_order_%0d", k), 64'(freq_log[s_log + k]), 64'h0A01 + 64'(k));
        check("q_empty_after", 64'(Q_LEVEL), 64'd0);

        // Late start loads immediately
        snap(); t0 = TIME;
        push(48'hC01, t0 - 64'd10, 16'd1, 1'b0);
        wait_done(s_done + 1, 500, "late_done_seen");
        check("late_pulse", 64'(m_late - s_late), 64'd1);
        check("late_req_time", m_req_time, t0 + 64'd3);

        // N=0 command is discarded without activity
        snap();
        push(48'hBAD, 64'd0, 16'd0, 1'b0);
        repeat (6) @(negedge CLK);
        check("err_pulse", 64'(m_err - s_err), 64'd1);
        check("err_no_req", 64'(m_req_rise - s_req), 64'd0);
        check("err_no_iz", 64'(m_iz_rise - s_iz_rise), 64'd0);
        check("err_q_empty", 64'(Q_LEVEL), 64'd0);

        // ABORT during TX of the first of three pulses, with a second command queued
        snap(); t0 = TIME + 64'd20;
        push(48'hD01, t0, 16'd3, 1'b0);
        push(48'hD02, t0, 16'd1, 1'b0);
        for (int i = 0; i < 300 && !EN_IZ; i++) @(negedge CLK);
        check("abort_tx_seen", 64'(EN_IZ), 64'd1);
        check("abort_q_before", 64'(Q_LEVEL), 64'd1);
        ABORT = 1'b1;
        @(posedge CLK);
        #1 check("abort_en_iz", 64'(EN_IZ), 64'd0);
        check("abort_q_level", 64'(Q_LEVEL), 64'd0);
        check("abort_dds_start", 64'(DDS_START), 64'd0);
        @(negedge CLK);
        ABORT = 1'b0;
        repeat (100) @(negedge CLK);
        check("abort_no_done", 64'(m_done - s_done), 64'd0);
        check("abort_no_more_tx", 64'(m_iz_rise - s_iz_rise), 64'd1);

        // RESET during RX
        t0 = TIME + 64'd20;
        push(48'hE01, t0, 16'd2, 1'b1);
        for (int i = 0; i < 300 && !EN_PR; i++) @(negedge CLK);
        check("rstrx_rx_seen", 64'(EN_PR), 64'd1);
        RESET = 1'b1;
        @(posedge CLK);
        #1 check("rstrx_en_pr", 64'(EN_PR), 64'd0);
        check("rstrx_time", TIME, 64'd0);
        check("rstrx_dds_start", 64'(DDS_START), 64'd0);
        check("rstrx_dds_freq", 64'(DDS_FREQ), 64'hFFFF_FFFF_FFFF);
        check("rstrx_ready", 64'(CMD_READY), 64'd1);
        @(negedge CLK);
        RESET = 1'b0;
        repeat (40) @(negedge CLK);
        check("rstrx_idle_iz", 64'(EN_IZ), 64'd0);
        check("rstrx_idle_req", 64'(DDS_REQ), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
